// File: rtl/dmem_arbiter.sv
// Two-port round-robin data-memory arbiter with bounded bursts.
// Port 0 is the core load/store path, port 1 the debug/loader master.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4,
  parameter int PRIO      = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  localparam logic [3:0] MAXB = 4'(MAX_BURST);
  localparam logic LAST_RST = (PRIO == 0) ? 1'b1 : 1'b0;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          g0, g1, gv;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          rv0_q, rv1_q;
  logic [DW-1:0] rd0_q, rd1_q;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (1'b1)
      (p0_req && !p1_req): g0 = 1'b1;
      (p1_req && !p0_req): g1 = 1'b1;
      (p0_req && p1_req): begin
        if (state_q == OWN0) begin
          g0 = (cnt_q < MAXB);
          g1 = !(cnt_q < MAXB);
        end else if (state_q == OWN1) begin
          g1 = (cnt_q < MAXB);
          g0 = !(cnt_q < MAXB);
        end else begin
          g0 = last_q;
          g1 = !last_q;
        end
      end
      default: ;
    endcase
  end

  // Grants are masked so outputs hit reset values the instant reset asserts.
  assign p0_gnt = g0 && reset;
  assign p1_gnt = g1 && reset;
  assign gv     = p0_gnt || p1_gnt;

  always_comb begin
    state_d = IDLE;
    cnt_d   = 4'd0;
    last_d  = last_q;
    if (p0_gnt) begin
      state_d = OWN0;
      last_d  = 1'b0;
      if (state_q == OWN0)
        cnt_d = (cnt_q >= MAXB) ? MAXB : cnt_q + 4'd1;
      else
        cnt_d = 4'd1;
    end else if (p1_gnt) begin
      state_d = OWN1;
      last_d  = 1'b1;
      if (state_q == OWN1)
        cnt_d = (cnt_q >= MAXB) ? MAXB : cnt_q + 4'd1;
      else
        cnt_d = 4'd1;
    end
  end

  assign mem_we    = gv && (p1_gnt ? p1_we : p0_we);
  assign mem_addr  = gv ? (p1_gnt ? p1_addr : p0_addr) : addr_q;
  assign mem_wdata = gv ? (p1_gnt ? p1_wdata : p0_wdata) : wdata_q;

  assign p0_rvalid = rv0_q;
  assign p1_rvalid = rv1_q;
  assign p0_rdata  = rv0_q ? mem_rdata : rd0_q;
  assign p1_rdata  = rv1_q ? mem_rdata : rd1_q;
  assign owner     = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= LAST_RST;
      addr_q  <= '0;
      wdata_q <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      if (gv) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
      rv0_q <= p0_gnt && !p0_we;
      rv1_q <= p1_gnt && !p1_we;
      if (rv0_q)
        rd0_q <= mem_rdata;
      if (rv1_q)
        rd1_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous memory model.
// Each scenario task drives stimulus and checks its own expectations.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0;
  logic        p0_gnt, p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [31:0] p1_addr = '0, p1_wdata = '0;
  logic        p1_gnt, p1_rvalid;
  logic [31:0] p1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  owner;

  int chk = 0;
  int err = 0;

  logic [31:0] mem [0:255];

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4), .PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we)
      mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    p0_req = 1'b0; p0_we = 1'b0;
    p1_req = 1'b0; p1_we = 1'b0;
  endtask

  task automatic test_reset();
    idle_in();
    reset = 1'b0;
    #1;
    chk++;
    if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we} !== 5'b0) begin
      err++;
      $display("FAIL reset_ctrl got %b want 00000",
               {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we});
    end
    chk++;
    if ({p0_rdata, p1_rdata, mem_addr, mem_wdata, owner} !== '0) begin
      err++;
      $display("FAIL reset_data got %h %h %h %h %b want zeros",
               p0_rdata, p1_rdata, mem_addr, mem_wdata, owner);
    end
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_single_read();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h40;
    #1;
    chk++;
    if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0 || mem_addr !== 32'h40
        || mem_we !== 1'b0) begin
      err++;
      $display("FAIL rd_grant got g0=%b g1=%b addr=%h we=%b want 1 0 40 0",
               p0_gnt, p1_gnt, mem_addr, mem_we);
    end
    tick();
    idle_in();
    #1;
    chk++;
    if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h12345678
        || p1_rvalid !== 1'b0 || owner !== 2'b01) begin
      err++;
      $display("FAIL rd_return got rv=%b d=%h rv1=%b own=%b want 1 12345678 0 01",
               p0_rvalid, p0_rdata, p1_rvalid, owner);
    end
    chk++;
    if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin
      err++;
      $display("FAIL addr_hold got %h we=%b want 40 0", mem_addr, mem_we);
    end
    tick();
    #1;
    chk++;
    if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h12345678
        || owner !== 2'b00) begin
      err++;
      $display("FAIL rdata_hold got rv=%b d=%h own=%b want 0 12345678 00",
               p0_rvalid, p0_rdata, owner);
    end
  endtask

  task automatic test_write_then_read();
    p1_req = 1'b1; p1_we = 1'b1;
    p1_addr = 32'h80; p1_wdata = 32'hDEADBEEF;
    #1;
    chk++;
    if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || mem_we !== 1'b1
        || mem_addr !== 32'h80 || mem_wdata !== 32'hDEADBEEF) begin
      err++;
      $display("FAIL wr_grant got g1=%b we=%b a=%h d=%h want 1 1 80 deadbeef",
               p1_gnt, mem_we, mem_addr, mem_wdata);
    end
    tick();
    idle_in();
    p0_req = 1'b1; p0_addr = 32'h80;
    #1;
    chk++;
    if (p0_gnt !== 1'b1 || mem_we !== 1'b0 || p1_rvalid !== 1'b0) begin
      err++;
      $display("FAIL wr_norv got g0=%b we=%b rv1=%b want 1 0 0",
               p0_gnt, mem_we, p1_rvalid);
    end
    tick();
    idle_in();
    #1;
    chk++;
    if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEADBEEF) begin
      err++;
      $display("FAIL wr_readback got rv=%b d=%h want 1 deadbeef",
               p0_rvalid, p0_rdata);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [8:0] pat;
    pat = 9'b0_1111_0000;
    test_reset();
    p0_req = 1'b1; p0_addr = 32'h10;
    p1_req = 1'b1; p1_addr = 32'h14;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk++;
      if (p1_gnt !== pat[i] || p0_gnt !== !pat[i]) begin
        err++;
        $display("FAIL rr_cycle%0d got g0=%b g1=%b want g1=%b",
                 i, p0_gnt, p1_gnt, pat[i]);
      end
      tick();
    end
    idle_in();
    tick();
  endtask

  task automatic test_saturate();
    test_reset();
    p0_req = 1'b1; p0_addr = 32'h20;
    for (int i = 0; i < 10; i++)
      tick();
    p1_req = 1'b1; p1_addr = 32'h24;
    #1;
    chk++;
    if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin
      err++;
      $display("FAIL sat_switch got g0=%b g1=%b want 0 1", p0_gnt, p1_gnt);
    end
    tick();
    idle_in();
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
    #1;
    chk++;
    if (p0_gnt !== 1'b1) begin
      err++;
      $display("FAIL b2b_g0 got %b want 1", p0_gnt);
    end
    tick();
    idle_in();
    p1_req = 1'b1; p1_addr = 32'h14;
    #1;
    chk++;
    if (p1_gnt !== 1'b1 || p0_rvalid !== 1'b1 || p1_rvalid !== 1'b0
        || p0_rdata !== 32'hA5A50010) begin
      err++;
      $display("FAIL b2b_rv0 got g1=%b rv0=%b rv1=%b d=%h want 1 1 0 a5a50010",
               p1_gnt, p0_rvalid, p1_rvalid, p0_rdata);
    end
    tick();
    idle_in();
    #1;
    chk++;
    if (p1_rvalid !== 1'b1 || p0_rvalid !== 1'b0
        || p1_rdata !== 32'h5A5A0014 || p0_rdata !== 32'hA5A50010) begin
      err++;
      $display("FAIL b2b_rv1 got rv1=%b rv0=%b d1=%h d0=%h want 1 0 5a5a0014 a5a50010",
               p1_rvalid, p0_rvalid, p1_rdata, p0_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h14;
    tick();
    idle_in();
    reset = 1'b0;
    #1;
    chk++;
    if (p1_rvalid !== 1'b0 || p1_rdata !== '0 || owner !== 2'b00
        || mem_addr !== '0 || mem_we !== 1'b0) begin
      err++;
      $display("FAIL rst_async got rv1=%b d=%h own=%b a=%h we=%b want zeros",
               p1_rvalid, p1_rdata, owner, mem_addr, mem_we);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk++;
      if (p1_rvalid !== 1'b0 || p0_rvalid !== 1'b0) begin
        err++;
        $display("FAIL rst_norv%0d got rv1=%b rv0=%b want 0 0",
                 i, p1_rvalid, p0_rvalid);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = 32'h0;
    mem[16] = 32'h12345678;
    mem[4]  = 32'hA5A50010;
    mem[5]  = 32'h5A5A0014;
    test_reset();
    test_single_read();
    test_write_then_read();
    test_round_robin();
    test_saturate();
    test_back_to_back();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
